// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size and common keyboard commands.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE,
      DONE,
      ERR
   } ps2_tx_state_t;

   // start + 8 data + parity + stop; the device ACK arrives on the following clock
   localparam int unsigned FRAME_BITS = 11;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

endpackage

// File: rtl/ps2_host_tx_if.sv
// Processor-side byte handshake for the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (output tx_data, tx_valid,
                   input  tx_ready, tx_busy, tx_done, tx_error);
   modport slave  (input  tx_data, tx_valid,
                   output tx_ready, tx_busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a registered
// falling-edge flag on the synchronized clock. Shared with the receive path.
module ps2_line_sync (
   input  logic clock,
   input  logic resetn,
   input  logic clk_pad,
   input  logic data_pad,
   output logic sync_clk,
   output logic sync_data,
   output logic fe
);

   logic clk_s1;
   logic data_s1;

   // Synchronizer chains; idle-high reset so no edge is seen coming out of reset.
   // fe is registered: it is high in the cycle where previous sync_clk=1 and sync_clk=0.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_s1    <= 1'b1;
         sync_clk  <= 1'b1;
         data_s1   <= 1'b1;
         sync_data <= 1'b1;
         fe        <= 1'b0;
      end else begin
         clk_s1    <= clk_pad;
         sync_clk  <= clk_s1;
         data_s1   <= data_pad;
         sync_data <= data_s1;
         fe        <= sync_clk & ~clk_s1;
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame shifted
// on device clock falling edges, ACK check, timeout.
// Optional feature macro: PS2_HOST_TX_RETRY_EN (up to two automatic retries).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic          clock,
   input  logic          resetn,
   ps2_host_tx_if.slave  tx,
   input  logic          ps2_clock_in,
   input  logic          ps2_data_in,
   output logic          ps2_clock_oe,
   output logic          ps2_data_oe
);

   localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

   // Reject parameter sets that cannot produce a working sequence
   if (CLK_FREQ_HZ == 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("ps2_host_tx: invalid parameters");
   end

   ps2_tx_state_t      state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [BIT_W-1:0]   bitcnt, bitcnt_n;
   logic [7:0]         shreg, shreg_n;
   logic               parity, parity_n;
   logic               data_oe_n, clock_oe_n;
   logic               ready_n, busy_n, done_n, error_n;
   logic               fail_c;
   logic               timeout_c;
   logic               sync_clk, sync_data, fe;
`ifdef PS2_HOST_TX_RETRY_EN
   logic [1:0]         retry, retry_n;
`endif

   ps2_line_sync u_sync (
      .clock     (clock),
      .resetn    (resetn),
      .clk_pad   (ps2_clock_in),
      .data_pad  (ps2_data_in),
      .sync_clk  (sync_clk),
      .sync_data (sync_data),
      .fe        (fe)
   );

   assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next-state, datapath and next-output decode
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bitcnt_n  = bitcnt;
      shreg_n   = shreg;
      parity_n  = parity;
      data_oe_n = 1'b0;
      fail_c    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_n   = retry;
`endif

      case (state)
         IDLE: begin
            if (tx.tx_valid) begin
               shreg_n  = tx.tx_data;
               parity_n = ~^tx.tx_data;
               cnt_n    = '0;
               state_n  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
               retry_n  = 2'd0;
`endif
            end
         end
         INHIBIT: begin
            if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
               cnt_n     = '0;
               data_oe_n = 1'b1;
               state_n   = REQ;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         REQ: begin
            // start bit stays on the line as the clock is released
            data_oe_n = 1'b1;
            cnt_n     = '0;
            bitcnt_n  = '0;
            state_n   = SHIFT;
         end
         SHIFT: begin
            data_oe_n = ps2_data_oe;
            if (fe) begin
               cnt_n    = '0;
               bitcnt_n = bitcnt + BIT_W'(1);
               if (bitcnt < BIT_W'(8)) begin
                  data_oe_n = ~shreg[bitcnt[2:0]];
               end else if (bitcnt == BIT_W'(8)) begin
                  data_oe_n = ~parity;
               end else begin
                  data_oe_n = 1'b0;
                  state_n   = ACK;
               end
            end else if (timeout_c) begin
               fail_c = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ACK: begin
            if (fe) begin
               cnt_n = '0;
               if (!sync_data) state_n = WAIT_IDLE;
               else            fail_c  = 1'b1;
            end else if (timeout_c) begin
               fail_c = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (sync_clk && sync_data) begin
               state_n = DONE;
            end else if (fe) begin
               cnt_n = '0;
            end else if (timeout_c) begin
               fail_c = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DONE:    state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Failed attempt: either retry from inhibit with the latched byte, or report
      if (fail_c) begin
         data_oe_n = 1'b0;
         cnt_n     = '0;
`ifdef PS2_HOST_TX_RETRY_EN
         if (retry < 2'd2) begin
            retry_n = retry + 2'd1;
            state_n = INHIBIT;
         end else begin
            state_n = ERR;
         end
`else
         state_n = ERR;
`endif
      end

      clock_oe_n = (state_n == INHIBIT) || (state_n == REQ);
      ready_n    = (state_n == IDLE);
      busy_n     = (state_n != IDLE);
      done_n     = (state_n == DONE);
      error_n    = (state_n == ERR);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         cnt          <= '0;
         bitcnt       <= '0;
         shreg        <= '0;
         parity       <= 1'b0;
         ps2_clock_oe <= 1'b0;
         ps2_data_oe  <= 1'b0;
         tx.tx_ready  <= 1'b1;
         tx.tx_busy   <= 1'b0;
         tx.tx_done   <= 1'b0;
         tx.tx_error  <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
         retry        <= 2'd0;
`endif
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         bitcnt       <= bitcnt_n;
         shreg        <= shreg_n;
         parity       <= parity_n;
         ps2_clock_oe <= clock_oe_n;
         ps2_data_oe  <= data_oe_n;
         tx.tx_ready  <= ready_n;
         tx.tx_busy   <= busy_n;
         tx.tx_done   <= done_n;
         tx.tx_error  <= error_n;
`ifdef PS2_HOST_TX_RETRY_EN
         retry        <= retry_n;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain pad model and a device BFM.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned INH  = 20;
   localparam int unsigned TO   = 200;
   localparam int unsigned HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic ps2_clock_oe, ps2_data_oe;
   logic ps2_clock_in, ps2_data_in;
   logic bfm_clk_low = 1'b0;
   logic bfm_data_low = 1'b0;

   ps2_host_tx_if txi ();

   assign ps2_clock_in = ~(ps2_clock_oe | bfm_clk_low);
   assign ps2_data_in  = ~(ps2_data_oe | bfm_data_low);

   ps2_host_tx #(
      .CLK_FREQ_HZ    (50_000_000),
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .tx           (txi),
      .ps2_clock_in (ps2_clock_in),
      .ps2_data_in  (ps2_data_in),
      .ps2_clock_oe (ps2_clock_oe),
      .ps2_data_oe  (ps2_data_oe)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0, err_cnt = 0, inh_cnt = 0, req_cyc = 0, req_rise = 0;
   int since_rel = 0, err_since_rel = -1;
   logic prev_ready = 1'b1, prev_clk_oe = 1'b0, prev_req = 1'b0, data_at_rel = 1'b0;
   bit scramble = 1'b0, drop_on_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      done_cnt = 0; err_cnt = 0; inh_cnt = 0; req_cyc = 0; req_rise = 0; err_since_rel = -1;
   endtask

   // One system cycle; sample just after the rising edge and track line/handshake activity
   task automatic tick();
      logic exp_busy;
      logic is_req;
      @(posedge clock);
      #1;
      if (scramble) txi.tx_data = 8'($urandom);
      if (prev_clk_oe && !ps2_clock_oe) begin
         since_rel   = 0;
         data_at_rel = ps2_data_oe;
      end else begin
         since_rel++;
      end
      prev_clk_oe = ps2_clock_oe;
      if (txi.tx_done) begin
         done_cnt++;
         if (drop_on_done) txi.tx_valid = 1'b0;
      end
      if (txi.tx_error) begin
         err_cnt++;
         err_since_rel = since_rel;
      end
      if (txi.tx_done || txi.tx_error)
         check("done_err_exclusive", {31'b0, txi.tx_done & txi.tx_error}, 32'd0);
      if (txi.tx_ready !== prev_ready) begin
         exp_busy = ~txi.tx_ready;
         check("busy_vs_ready", {31'b0, txi.tx_busy}, {31'b0, exp_busy});
      end
      prev_ready = txi.tx_ready;
      if (ps2_clock_oe && !ps2_data_oe) inh_cnt++;
      is_req = ps2_clock_oe & ps2_data_oe;
      if (is_req) req_cyc++;
      if (is_req && !prev_req) req_rise++;
      prev_req = is_req;
   endtask

   task automatic send(input logic [7:0] b);
      txi.tx_data  = b;
      txi.tx_valid = 1'b1;
      tick();
      txi.tx_valid = 1'b0;
   endtask

   // Wait for clock released with the start bit driven
   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!ps2_clock_oe && ps2_data_oe) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // One device clock: high half (sample at its end), then low half
   task automatic bfm_cycle(output logic smp);
      repeat (HALF) tick();
      smp = ps2_data_in;
      bfm_clk_low = 1'b1;
      repeat (HALF) tick();
      bfm_clk_low = 1'b0;
   endtask

   task automatic bfm_frame(input bit ack, output logic [10:0] bits);
      logic smp;
      for (int i = 0; i < 10; i++) begin
         bfm_cycle(smp);
         bits[i] = smp;
      end
      repeat (HALF) tick();
      bits[10] = ps2_data_in;
      bfm_data_low = ack;
      repeat (5) tick();
      bfm_clk_low = 1'b1;
      repeat (HALF) tick();
      bfm_clk_low = 1'b0;
      repeat (5) tick();
      bfm_data_low = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [10:0] bits;
      logic smp;

      txi.tx_data  = 8'h00;
      txi.tx_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready",    {31'b0, txi.tx_ready}, 32'd1);
      check("rst_busy",     {31'b0, txi.tx_busy},  32'd0);
      check("rst_done",     {31'b0, txi.tx_done},  32'd0);
      check("rst_error",    {31'b0, txi.tx_error}, 32'd0);
      check("rst_clock_oe", {31'b0, ps2_clock_oe}, 32'd0);
      check("rst_data_oe",  {31'b0, ps2_data_oe},  32'd0);
      resetn = 1'b1;
      repeat (2) tick();

      // 0xED: start 0, data LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1 -> 11'h7DA
      clear_mon();
      send(PS2_CMD_SET_LEDS);
      wait_req(ok);
      check("ed_req_seen", {31'b0, ok}, 32'd1);
      bfm_frame(1'b1, bits);
      repeat (5) tick();
      check("ed_frame", {21'b0, bits}, 32'h7DA);
      check("ed_done",  32'(done_cnt), 32'd1);
      check("ed_err",   32'(err_cnt),  32'd0);
      check("ed_ready", {31'b0, txi.tx_ready}, 32'd1);

      // 0xF4: five ones -> parity 0 -> 11'h5E8; inhibit and request timing
      clear_mon();
      send(PS2_CMD_ENABLE);
      wait_req(ok);
      check("f4_req_seen", {31'b0, ok}, 32'd1);
      check("f4_inhibit_cycles", 32'(inh_cnt), 32'd20);
      check("f4_req_cycles",     32'(req_cyc), 32'd1);
      check("f4_data_at_release", {31'b0, data_at_rel}, 32'd1);
      bfm_frame(1'b1, bits);
      repeat (5) tick();
      check("f4_frame", {21'b0, bits}, 32'h5E8);
      check("f4_done",  32'(done_cnt), 32'd1);

      // Device never clocks: error TO cycles after the clock release
      clear_mon();
      send(8'h55);
      for (int i = 0; i < 1500; i++) begin
         if (err_cnt != 0) break;
         tick();
      end
      check("to_err",      32'(err_cnt), 32'd1);
      check("to_latency",  32'(err_since_rel), 32'd200);
      check("to_attempts", 32'(req_rise), 32'(ATTEMPTS));
      check("to_clock_oe", {31'b0, ps2_clock_oe}, 32'd0);
      check("to_data_oe",  {31'b0, ps2_data_oe},  32'd0);
      tick();
      check("to_ready", {31'b0, txi.tx_ready}, 32'd1);
      check("to_done",  32'(done_cnt), 32'd0);

      // Missing ACK: 0x12 has two ones -> parity 1 -> 11'h624
      clear_mon();
      send(8'h12);
      for (int a = 0; a < ATTEMPTS; a++) begin
         wait_req(ok);
         check("nack_req_seen", {31'b0, ok}, 32'd1);
         bfm_frame(1'b0, bits);
         check("nack_frame", {21'b0, bits}, 32'h624);
      end
      repeat (5) tick();
      check("nack_err",      32'(err_cnt),  32'd1);
      check("nack_done",     32'(done_cnt), 32'd0);
      check("nack_attempts", 32'(req_rise), 32'(ATTEMPTS));

      // Reset asserted just after the 5th device falling edge of 0x00
      clear_mon();
      send(8'h00);
      wait_req(ok);
      check("rst_req_seen", {31'b0, ok}, 32'd1);
      repeat (4) bfm_cycle(smp);
      repeat (HALF) tick();
      bfm_clk_low = 1'b1;
      repeat (4) tick();
      check("pre_rst_data_oe", {31'b0, ps2_data_oe}, 32'd1);
      resetn = 1'b0;
      #1;
      check("mid_rst_clock_oe", {31'b0, ps2_clock_oe}, 32'd0);
      check("mid_rst_data_oe",  {31'b0, ps2_data_oe},  32'd0);
      check("mid_rst_ready",    {31'b0, txi.tx_ready}, 32'd1);
      bfm_clk_low = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      repeat (30) tick();
      check("post_rst_done", 32'(done_cnt), 32'd0);
      check("post_rst_err",  32'(err_cnt),  32'd0);

      // New request after reset release: 0xFF -> parity 1 -> 11'h7FE
      clear_mon();
      send(PS2_CMD_RESET);
      wait_req(ok);
      check("ff_req_seen", {31'b0, ok}, 32'd1);
      bfm_frame(1'b1, bits);
      repeat (5) tick();
      check("ff_frame", {21'b0, bits}, 32'h7FE);
      check("ff_done",  32'(done_cnt), 32'd1);

      // tx_valid held during busy while tx_data changes: 0x3C -> parity 1 -> 11'h678
      clear_mon();
      drop_on_done = 1'b1;
      txi.tx_data  = 8'h3C;
      txi.tx_valid = 1'b1;
      tick();
      scramble = 1'b1;
      wait_req(ok);
      check("hold_req_seen", {31'b0, ok}, 32'd1);
      bfm_frame(1'b1, bits);
      repeat (5) tick();
      scramble = 1'b0;
      drop_on_done = 1'b0;
      repeat (40) tick();
      check("hold_frame",    {21'b0, bits}, 32'h678);
      check("hold_done",     32'(done_cnt), 32'd1);
      check("hold_accepts",  32'(req_rise), 32'd1);
      check("hold_ready",    {31'b0, txi.tx_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the send-side counterpart to the existing PS/2 receive path and lets the processor send commands to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset).
It drives the open-drain ps2_clock/ps2_data pads through output-enables, runs the request-to-send sequence, shifts out an 11-bit frame on device-generated clocks, and checks the device ACK.
It sits beside the PS/2 receiver in the top level; tx_busy tells the receiver to ignore line activity during a transmission.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency (documentation/derivation only)
INHIBIT_CYCLES, 6000, clock-low hold before request (120 us at 50 MHz; spec minimum 100 us)
TIMEOUT_CYCLES, 750000, max system cycles between device clock falling edges (15 ms at 50 MHz)

Ports:
clock  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted on the cycle where tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
ps2_clock_in  in  1  raw PS/2 clock pad value (asynchronous)
ps2_data_in  in  1  raw PS/2 data pad value (asynchronous)
ps2_clock_oe  out  1  1 = pull PS/2 clock low; 0 = release
ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: frame sent and ACK received
tx_error  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE; ps2_clock_oe=0, ps2_data_oe=0 (both lines released).
  - tx_ready=1; tx_busy=0; tx_done=0; tx_error=0; all counters cleared.
- Input conditioning:
  - ps2_clock_in and ps2_data_in each pass through a 2-flop synchronizer.
  - A falling edge ("fe") is sync_clk_prev=1 && sync_clk=0. Detection latency is 3 cycles from the pad.
- Accept:
  - On the accept cycle, latch tx_data into shreg and latch parity = ~^tx_data (odd parity).
  - Next state is INHIBIT. tx_valid is ignored whenever tx_ready=0.
- INHIBIT:
  - clock_oe=1, data_oe=0.
  - Stays INHIBIT_CYCLES cycles, then moves to REQ.
- REQ:
  - clock_oe=1, data_oe=1 (start bit) for exactly 1 cycle, then moves to SHIFT with clock_oe=0 and data_oe held at 1.
  - bitcnt=0; the timeout counter is cleared.
- SHIFT (advances on each fe; bitcnt increments per fe):
  - fe 1..8: data_oe = ~shreg[bitcnt-1] (LSB first).
  - fe 9: data_oe = ~parity.
  - fe 10: data_oe=0 (stop bit, line released); go to ACK.
- ACK:
  - On fe 11, sample sync_data.
  - 0 → WAIT_IDLE. 1 → ERR.
- WAIT_IDLE:
  - Wait until sync_clk=1 && sync_data=1, then DONE.
- DONE:
  - tx_done=1 for one cycle, then IDLE.
- ERR:
  - Both oe=0; tx_error=1 for one cycle, then IDLE.
- Timeout:
  - In SHIFT, ACK and WAIT_IDLE, the counter increments every cycle and clears on each fe.
  - When it reaches TIMEOUT_CYCLES-1, go to ERR.
- tx_done and tx_error are never high in the same cycle.
- Glitches shorter than one system cycle may be missed; that is acceptable.
- A device clock edge during INHIBIT or REQ is ignored.

Optional Feature:
PS2_HOST_TX_RETRY_EN
- Defined:
  - A 2-bit retry counter, cleared on accept.
  - On the ERR condition with retries<2: increment, and re-enter INHIBIT with the latched byte instead of pulsing tx_error.
  - tx_error pulses only after the 3rd failed attempt.
  - tx_busy stays high across retries.
- Undefined:
  - The first failure pulses tx_error.
  - No retry logic or counter is synthesized.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR);
  - FRAME_BITS=11;
  - PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
- One sub-module: ps2_line_sync (2-flop synchronizers plus falling-edge detect).
  - It is reusable by the receiver.

Test Plan (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device BFM clock period 40 cycles):
- tx_data=0xED, BFM ACKs → data sampled on device rising edges is start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_busy drops the same cycle tx_ready rises.
- tx_data=0xF4 → parity bit 0; clock_oe held low exactly 20 cycles; data_oe asserted 1 cycle before clock_oe releases.
- BFM never clocks after the request → tx_error pulses 200 cycles after REQ; both oe=0; tx_ready=1.
- BFM leaves data high on clock 11 → tx_error=1, tx_done=0. With PS2_HOST_TX_RETRY_EN, 3 full frames are observed before a single tx_error.
- Assert resetn=0 at fe 5 of 0x00 → both oe=0 in the same cycle; no done or error pulse; a new tx_valid after release is accepted.
- tx_valid held high during busy with tx_data changing → the transmitted byte equals the value at the accept cycle.
